fifo_burst_drain_ctrl: RTL and testbench

Scheduler that drains the pixel sync_fifo into the downstream frame-buffer writer in fixed-length bursts. It watches FIFO fill and requests the memory port when a full burst is available. On an end-of-frame pulse it flushes the remaining partial data. It generates the FIFO read strobe, the burst length and the frame-relative word address, sitting between the camera-side FIFO and the memory arbiter.

---
 rtl/fifo_ctrl_pkg.sv | 22 ++
 rtl/fifo_burst_drain_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_burst_drain_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and parameter helpers for the FIFO burst-drain scheduler.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StXfer,
    StSettle
  } drain_state_e;

  localparam int unsigned BurstDefault      = 16;
  localparam int unsigned FrameWordsDefault = 76800;

  function automatic int unsigned calc_lw(int unsigned burst);
    return $clog2(burst) + 1;
  endfunction

  function automatic int unsigned calc_addr_w(int unsigned frame_words);
    return $clog2(frame_words);
  endfunction

endpackage

// File: rtl/fifo_burst_drain_ctrl.sv
// Drains the pixel FIFO into the frame-buffer writer in fixed bursts, flushing the
// partial tail on end-of-frame and tracking the frame-relative word address.
module fifo_burst_drain_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 10,
  parameter int unsigned BURST       = BurstDefault,
  parameter int unsigned LW          = calc_lw(BURST),
  parameter int unsigned FRAME_WORDS = FrameWordsDefault,
  parameter int unsigned ADDR_W      = calc_addr_w(FRAME_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fifo_empty,
  input  logic [AW:0]       i_fifo_fill,
  input  logic [DW-1:0]     i_fifo_data,
  output logic              o_fifo_rd,
  input  logic              i_frame_end,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic [LW-1:0]     o_mem_len,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_valid,
  output logic [DW-1:0]     o_mem_data,
  input  logic              i_mem_ready,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam logic [AW:0]     BurstFill     = (AW+1)'(BURST);
  localparam logic [LW-1:0]   BurstLen      = LW'(BURST);
  localparam logic [LW-1:0]   OneLen        = LW'(1);
  localparam logic [ADDR_W:0] FrameWordsExt = (ADDR_W+1)'(FRAME_WORDS);

  drain_state_e      state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              flush_q, flush_d;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] addr_next;

  // One extra bit so the sum never overflows before the frame wrap is applied.
  always_comb begin
    addr_sum  = {1'b0, addr_q} + (ADDR_W+1)'(len_q);
    addr_next = (addr_sum >= FrameWordsExt) ? ADDR_W'(addr_sum - FrameWordsExt)
                                            : addr_sum[ADDR_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rem_d        = rem_q;
    addr_d       = addr_q;
    flush_d      = flush_q;
    o_mem_req    = 1'b0;
    o_mem_valid  = 1'b0;
    o_fifo_rd    = 1'b0;
    o_frame_done = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_fifo_fill >= BurstFill) begin
          len_d   = BurstLen;
          state_d = StReq;
        end else if (flush_q && (i_fifo_fill != '0)) begin
          len_d   = LW'(i_fifo_fill);
          state_d = StReq;
        end else if (flush_q) begin
          o_frame_done = 1'b1;
          flush_d      = 1'b0;
          addr_d       = '0;
        end
      end
      StReq: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) begin
          rem_d   = len_q;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // An empty flag here is only a stall; the latched length is always in the FIFO.
        o_mem_valid = !i_fifo_empty && (rem_q != '0);
        o_fifo_rd   = o_mem_valid && i_mem_ready;
        if (o_fifo_rd) begin
          rem_d = rem_q - OneLen;
          if (rem_q == OneLen) begin
            addr_d  = addr_next;
            state_d = StSettle;
          end
        end
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A frame-end arriving with the done pulse must survive the clear.
    if (i_frame_end) flush_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
    end
  end

  assign o_mem_len  = len_q;
  assign o_mem_addr = addr_q;
  assign o_mem_data = o_mem_valid ? i_fifo_data : '0;
  assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_burst_drain_ctrl.sv
// Bench for fifo_burst_drain_ctrl: queue-based FIFO and memory-side models around the DUT,
// with a burst/word-level reference model derived from the drain rules.
module tb_fifo_burst_drain_ctrl;

  localparam int unsigned DW     = 8;
  localparam int unsigned AW     = 10;
  localparam int unsigned BURST  = 16;
  localparam int unsigned LW     = 5;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned FW     = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic [AW:0]       fifo_fill;
  logic [DW-1:0]     fifo_data;
  logic              fifo_rd;
  logic              frame_end;
  logic              mem_req;
  logic              mem_gnt;
  logic [LW-1:0]     mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [DW-1:0]     mem_data;
  logic              mem_ready;
  logic              frame_done;
  logic              busy;

  always #5 clk = ~clk;

  fifo_burst_drain_ctrl #(
    .DW(DW), .AW(AW), .BURST(BURST), .LW(LW), .FRAME_WORDS(FW), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_fifo_empty(fifo_empty), .i_fifo_fill(fifo_fill),
    .i_fifo_data(fifo_data), .o_fifo_rd(fifo_rd), .i_frame_end(frame_end),
    .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .o_mem_len(mem_len), .o_mem_addr(mem_addr),
    .o_mem_valid(mem_valid), .o_mem_data(mem_data), .i_mem_ready(mem_ready),
    .o_frame_done(frame_done), .o_busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // FIFO model contents and write port
  logic [DW-1:0] fq[$];
  logic          wr_en;
  logic [DW-1:0] wr_data;

  // Reference model: expected words, bursts and done pulses
  logic [DW-1:0] exp_data[$];
  int unsigned   exp_len[$];
  int unsigned   exp_addr[$];
  int unsigned   m_addr, m_pending;
  int            exp_done, seen_done;

  // Memory-side model and observations
  int          ready_mode, req_hold, hold_rand, req_n, last_req_n;
  int unsigned cur_len, cur_addr;
  int          beats, total_beats, total_rd, cyc, first_beat_cyc, last_beat_cyc;
  int          post_stage;
  logic        post1_busy, post1_quiet, post2_busy;
  logic        s_req, s_valid, s_rd, s_done, s_busy;
  logic [DW-1:0]     s_data;
  logic [LW-1:0]     s_len;
  logic [ADDR_W-1:0] s_addr;

  task automatic m_write(input logic [DW-1:0] w);
    exp_data.push_back(w);
    m_pending++;
    if (m_pending == BURST) begin
      exp_len.push_back(BURST);
      exp_addr.push_back(m_addr);
      m_addr    = (m_addr + BURST) % FW;
      m_pending = 0;
    end
  endtask

  task automatic m_frame_end();
    if (m_pending != 0) begin
      exp_len.push_back(m_pending);
      exp_addr.push_back(m_addr);
      m_pending = 0;
    end
    m_addr = 0;
    exp_done++;
  endtask

  // One clock: sample just after the negedge, check, advance models, drive next inputs.
  task automatic tick();
    int   old_sz;
    logic nxt_gnt, nxt_ready;
    #1;
    s_req = mem_req; s_valid = mem_valid; s_rd = fifo_rd; s_done = frame_done;
    s_busy = busy; s_data = mem_data; s_len = mem_len; s_addr = mem_addr;
    cyc++;
    if (post_stage == 1) begin
      post1_busy = s_busy; post1_quiet = !s_req && !s_valid; post_stage = 2;
    end else if (post_stage == 2) begin
      post2_busy = s_busy; post_stage = 0;
    end
    if (s_done) seen_done++;
    if (s_req) begin
      if (req_n == 0) begin
        checks++;
        if (exp_len.size() == 0) begin
          errors++;
          $display("FAIL burst_unexpected: got len=%0d addr=%0d, required no burst", s_len, s_addr);
        end else begin
          cur_len  = exp_len.pop_front();
          cur_addr = exp_addr.pop_front();
          if (s_len !== LW'(cur_len) || s_addr !== ADDR_W'(cur_addr)) begin
            errors++;
            $display("FAIL burst_hdr: got len=%0d addr=%0d, required len=%0d addr=%0d",
                     s_len, s_addr, cur_len, cur_addr);
          end
        end
        beats = 0;
        if (hold_rand != 0) req_hold = int'($urandom_range(2, 5));
      end
      req_n++;
    end
    checks++;
    if (s_rd !== (s_valid && mem_ready)) begin
      errors++;
      $display("FAIL rd_rule: got rd=%0b, required %0b (valid=%0b ready=%0b)",
               s_rd, s_valid && mem_ready, s_valid, mem_ready);
    end
    if (s_rd) begin
      total_rd++;
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL pop_empty: got rd=1 with empty FIFO, required rd=0");
      end else if (exp_data.size() == 0 || s_data !== exp_data[0]) begin
        errors++;
        $display("FAIL beat_data: got %0h, required %0h", s_data,
                 (exp_data.size() != 0) ? exp_data[0] : '0);
      end
      if (exp_data.size() != 0) void'(exp_data.pop_front());
      checks++;
      if (s_len !== LW'(cur_len) || s_addr !== ADDR_W'(cur_addr)) begin
        errors++;
        $display("FAIL hdr_stable: got len=%0d addr=%0d, required len=%0d addr=%0d",
                 s_len, s_addr, cur_len, cur_addr);
      end
      beats++; total_beats++;
      if (beats == 1) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      if (beats == int'(cur_len)) post_stage = 1;
    end
    nxt_gnt = s_req && !mem_gnt && (req_n + 1 >= req_hold);
    if (s_req && mem_gnt) begin
      last_req_n = req_n;
      req_n      = 0;
    end
    old_sz = fq.size();
    if (s_rd && fq.size() != 0) void'(fq.pop_front());
    if (wr_en) fq.push_back(wr_data);
    case (ready_mode)
      0:       nxt_ready = 1'b1;
      1:       nxt_ready = ~mem_ready;
      default: nxt_ready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    fifo_fill  = (AW+1)'(old_sz);
    fifo_empty = (old_sz == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    mem_gnt    = nxt_gnt;
    mem_ready  = nxt_ready;
    wr_en      = 1'b0;
    frame_end  = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    wr_en = 1'b1; wr_data = w;
    m_write(w);
    tick();
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    m_frame_end();
    tick();
  endtask

  task automatic drain(input int max_cycles, input string name);
    int n = 0;
    while (n < max_cycles && !(exp_len.size() == 0 && exp_data.size() == 0 &&
           seen_done >= exp_done && !s_busy && post_stage == 0 && req_n == 0)) begin
      tick(); n++;
    end
    repeat (4) tick();
    checks++;
    if (exp_len.size() != 0 || exp_data.size() != 0 || seen_done != exp_done) begin
      errors++;
      $display("FAIL %s_drain: got bursts_left=%0d words_left=%0d done=%0d, required 0 0 %0d",
               name, exp_len.size(), exp_data.size(), seen_done, exp_done);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; frame_end = 1'b0; mem_gnt = 1'b0; mem_ready = 1'b1;
    fifo_fill = '0; fifo_empty = 1'b1; fifo_data = '0;
    fq.delete(); exp_data.delete(); exp_len.delete(); exp_addr.delete();
    m_addr = 0; m_pending = 0; exp_done = 0; seen_done = 0;
    req_n = 0; last_req_n = 0; beats = 0; post_stage = 0; cur_len = 0; cur_addr = 0;
    ready_mode = 0; req_hold = 2; hold_rand = 0; s_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; frame_end = 1'b1; mem_gnt = 1'b0; mem_ready = 1'b1;
    fifo_fill = (AW+1)'(20); fifo_empty = 1'b0; fifo_data = 8'h5a;
    #1;
    checks++;
    if ({fifo_rd, mem_req, mem_valid, frame_done, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %05b, required 00000",
               {fifo_rd, mem_req, mem_valid, frame_done, busy});
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mem_len !== '0 || mem_addr !== '0 || mem_data !== '0) begin
      errors++;
      $display("FAIL reset_values: got len=%0d addr=%0d data=%0h, required 0 0 0",
               mem_len, mem_addr, mem_data);
    end
    checks++;
    if ({mem_req, busy, frame_done} !== 3'b0) begin
      errors++;
      $display("FAIL reset_hold: got req/busy/done=%03b, required 000",
               {mem_req, busy, frame_done});
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    req_hold = 3;
    for (int i = 0; i < 16; i++) push_word(DW'($urandom));
    drain(200, "single");
    checks++;
    if (last_req_n != 3) begin
      errors++; $display("FAIL req_hold: got %0d cycles, required 3", last_req_n);
    end
    checks++;
    if (last_beat_cyc - first_beat_cyc != 15) begin
      errors++;
      $display("FAIL beats_consecutive: got span %0d, required 15", last_beat_cyc - first_beat_cyc);
    end
    checks++;
    if (post1_busy !== 1'b1 || post1_quiet !== 1'b1 || post2_busy !== 1'b0) begin
      errors++;
      $display("FAIL settle: got busy=%0b quiet=%0b then busy=%0b, required 1 1 then 0",
               post1_busy, post1_quiet, post2_busy);
    end
    checks++;
    if (mem_addr !== ADDR_W'(16)) begin
      errors++; $display("FAIL addr_after_burst: got %0d, required 16", mem_addr);
    end
  endtask

  task automatic test_frame_flush();
    do_reset();
    for (int i = 0; i < 40; i++) push_word(DW'($urandom));
    pulse_frame_end();
    drain(400, "flush");
    checks++;
    if (mem_addr !== '0) begin
      errors++; $display("FAIL addr_after_frame: got %0d, required 0", mem_addr);
    end
  endtask

  task automatic test_ready_toggle();
    int base;
    do_reset();
    ready_mode = 1;
    base = total_beats;
    for (int i = 0; i < 32; i++) push_word(DW'($urandom));
    drain(400, "toggle");
    checks++;
    if (total_beats - base != 32) begin
      errors++; $display("FAIL toggle_beats: got %0d, required 32", total_beats - base);
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    ready_mode = 2; hold_rand = 1;
    for (int i = 0; i < 48; i++) push_word(DW'($urandom));
    drain(600, "wrap");
    checks++;
    if (mem_addr !== ADDR_W'(8)) begin
      errors++; $display("FAIL addr_wrap: got %0d, required 8", mem_addr);
    end
  endtask

  task automatic test_flush_race();
    logic [DW-1:0] w;
    do_reset();
    w = DW'($urandom);
    // Frame end with an empty FIFO; one word of the next frame lands in the same cycle.
    frame_end = 1'b1; wr_en = 1'b1; wr_data = w;
    m_frame_end(); m_write(w);
    tick();
    frame_end = 1'b1;
    m_frame_end();
    tick();
    checks++;
    if (s_done !== 1'b1) begin
      errors++; $display("FAIL race_done_cycle: got done=%0b, required 1", s_done);
    end
    drain(200, "race");
    checks++;
    if (mem_addr !== '0) begin
      errors++; $display("FAIL race_addr: got %0d, required 0", mem_addr);
    end
  endtask

  task automatic test_reset_mid_burst();
    int guard = 0;
    int rd_base;
    do_reset();
    for (int i = 0; i < 16; i++) push_word(DW'($urandom));
    while (!(s_rd && beats == 4) && guard < 200) begin
      tick(); guard++;
    end
    #1;
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++; $display("FAIL beat5_valid: got %0b, required 1", mem_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({fifo_rd, mem_req, mem_valid, frame_done, busy} !== 5'b0 || mem_addr !== '0 ||
        mem_len !== '0 || mem_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_burst: got flags=%05b addr=%0d len=%0d, required 0 0 0",
               {fifo_rd, mem_req, mem_valid, frame_done, busy}, mem_addr, mem_len);
    end
    exp_data.delete(); exp_len.delete(); exp_addr.delete();
    m_pending = 0; m_addr = 0; req_n = 0; post_stage = 0;
    @(negedge clk);
    rst = 1'b0;
    rd_base = total_rd;
    repeat (12) tick();
    checks++;
    if (total_rd != rd_base || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_pop_after_reset: got pops=%0d busy=%0b, required 0 0",
               total_rd - rd_base, s_busy);
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    ready_mode = 2; hold_rand = 1;
    for (int f = 0; f < 3; f++) begin
      n = int'($urandom_range(1, 70));
      for (int i = 0; i < n; i++) begin
        push_word(DW'($urandom));
        if ($urandom_range(0, 3) == 0) tick();
      end
      pulse_frame_end();
      drain(2000, "random");
      checks++;
      if (mem_addr !== '0) begin
        errors++; $display("FAIL random_addr: got %0d, required 0", mem_addr);
      end
    end
  endtask

  initial begin
    cyc = 0; total_beats = 0; total_rd = 0;
    test_reset();
    test_single_burst();
    test_frame_flush();
    test_ready_toggle();
    test_addr_wrap();
    test_flush_race();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
